// File: rtl/n64_cic_phy.sv
// n64_cic_phy: bit-level PHY for the N64 CIC serial link. Synchronizes the console pins,
// shifts MSB-first commands over the open-drain DQ line, and guards each command with timeout/abort.
module n64_cic_phy #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BITS    = 32,
  parameter int DIV_WIDTH   = 8,
  parameter int TIMEOUT     = 3815
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          n64_reset,
  input  logic                          n64_cic_clk,
  input  logic                          n64_si_clk,
  inout  wire                           n64_cic_dq,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [$clog2(MAX_BITS+1)-1:0] cmd_count,
  input  logic [MAX_BITS-1:0]           cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [MAX_BITS-1:0]           rsp_data,
  output logic                          rsp_timeout,
  output logic                          rsp_abort,
  output logic                          cic_reset,
  output logic                          cic_clk,
  output logic                          cic_dq
);
  localparam int CW = $clog2(MAX_BITS + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_FALL = 2'd1;
  localparam logic [1:0] ST_WAIT_RISE = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  logic [3:0]                  pins_s;
  logic [3:0]                  lvl_s;
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [1:0]                  dly_q, dly_d;
  logic                        clk_fall_s, clk_rise_s, si_rise_s;

  logic [1:0]           state_q, state_d;
  logic                 write_q, write_d;
  logic [MAX_BITS-1:0]  data_q, data_d;
  logic [CW-1:0]        rem_q, rem_d;
  logic [MAX_BITS-1:0]  rsp_data_q, rsp_data_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 rsp_abort_q, rsp_abort_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [TW-1:0]        timer_q, timer_d;

  logic                 busy_s, tick_s, expire_s, abort_s;
  logic [CW-1:0]        cnt_s;

  // Bit order within each stage: {dq, si_clk, cic_clk, reset}
  assign pins_s     = {n64_cic_dq, n64_si_clk, n64_cic_clk, n64_reset};
  assign lvl_s      = sync_q[SYNC_STAGES-1];
  assign cic_reset  = lvl_s[0];
  assign cic_clk    = lvl_s[1];
  assign cic_dq     = lvl_s[3];
  assign clk_fall_s = dly_q[0] & ~lvl_s[1];
  assign clk_rise_s = ~dly_q[0] & lvl_s[1];
  assign si_rise_s  = ~dly_q[1] & lvl_s[2];

  // Released combinationally as well so a reset frees the bus without waiting for the flop.
  assign n64_cic_dq = (dq_oe_q && !reset) ? 1'b0 : 1'bz;

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_abort   = rsp_abort_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pins_s};
    dly_d  = lvl_s[2:1];
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    data_d        = data_q;
    rem_d         = rem_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_abort_d   = rsp_abort_q;
    dq_oe_d       = dq_oe_q;
    presc_d       = presc_q;
    timer_d       = timer_q;
    tick_s        = 1'b0;
    expire_s      = 1'b0;

    if (cmd_count > CW'(MAX_BITS)) begin
      cnt_s = CW'(MAX_BITS);
    end else begin
      cnt_s = cmd_count;
    end

    // Timeout only runs while a command is on the wire and the console is out of reset.
    busy_s  = (state_q == ST_WAIT_FALL) || (state_q == ST_WAIT_RISE);
    abort_s = busy_s && !lvl_s[0];
    if (busy_s && si_rise_s && lvl_s[0]) begin
      presc_d = presc_q + DIV_WIDTH'(1);
      tick_s  = &presc_q;
    end else begin
      presc_d = presc_q;
    end
    if (tick_s && (timer_q != TW'(0))) begin
      timer_d  = timer_q - TW'(1);
      expire_s = (timer_q == TW'(1));
    end else begin
      timer_d = timer_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d       = cmd_write;
          data_d        = cmd_data << (CW'(MAX_BITS) - cnt_s);
          rem_d         = cnt_s;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          rsp_abort_d   = 1'b0;
          dq_oe_d       = 1'b0;
          presc_d       = '0;
          timer_d       = TW'(TIMEOUT);
          state_d       = (cnt_s == CW'(0)) ? ST_RESP : ST_WAIT_FALL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_FALL: begin
        if (abort_s || expire_s) begin
          dq_oe_d       = 1'b0;
          rsp_abort_d   = abort_s;
          rsp_timeout_d = expire_s;
          state_d       = ST_RESP;
        end else if (clk_fall_s) begin
          dq_oe_d = write_q ? ~data_q[MAX_BITS-1] : 1'b0;
          state_d = ST_WAIT_RISE;
        end else begin
          state_d = ST_WAIT_FALL;
        end
      end
      ST_WAIT_RISE: begin
        if (abort_s || expire_s) begin
          dq_oe_d       = 1'b0;
          rsp_abort_d   = abort_s;
          rsp_timeout_d = expire_s;
          state_d       = ST_RESP;
        end else if (clk_rise_s) begin
          if (!write_q) begin
            rsp_data_d    = rsp_data_q << 1;
            rsp_data_d[0] = lvl_s[3];
          end else begin
            rsp_data_d = rsp_data_q;
          end
          dq_oe_d = 1'b0;
          data_d  = data_q << 1;
          rem_d   = rem_q - CW'(1);
          state_d = (rem_q == CW'(1)) ? ST_RESP : ST_WAIT_FALL;
        end else begin
          state_d = ST_WAIT_RISE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        dq_oe_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      dly_q         <= 2'b00;
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      data_q        <= '0;
      rem_q         <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_abort_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      dq_oe_q       <= 1'b0;
      presc_q       <= '0;
      timer_q       <= '0;
    end else begin
      sync_q        <= sync_d;
      dly_q         <= dly_d;
      state_q       <= state_d;
      write_q       <= write_d;
      data_q        <= data_d;
      rem_q         <= rem_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_abort_q   <= rsp_abort_d;
      rsp_valid_q   <= rsp_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      dq_oe_q       <= dq_oe_d;
      presc_q       <= presc_d;
      timer_q       <= timer_d;
    end
  end

endmodule

// File: tb/tb_n64_cic_phy.sv
// Bench for n64_cic_phy: table of transmit/receive commands checked through a response
// scoreboard, plus hand sequences for console-reset abort, timeout and mid-command reset.
module tb_n64_cic_phy;
  localparam int SYNC = 2;

  typedef struct {
    logic        wr;
    logic [5:0]  cnt;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        tmo;
    logic        abt;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        n64_reset = 1'b1;
  logic        n64_cic_clk = 1'b1;
  logic        n64_si_clk = 1'b0;
  logic        tb_low = 1'b0;
  wire         dq_a;
  wire         dq_b;

  logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_count = 6'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_ready = 1'b0, rsp_ready2 = 1'b0;
  logic        cmd_ready, cmd_ready2, rsp_valid, rsp_valid2;
  logic [31:0] rsp_data, rsp_data2;
  logic        rsp_timeout, rsp_timeout2, rsp_abort, rsp_abort2;
  logic        cic_reset, cic_clk, cic_dq, cic_reset2, cic_clk2, cic_dq2;

  int checks = 0;
  int errors = 0;
  logic rx_mode = 1'b0;
  int rx_viol = 0;
  vec_t vecs[9];
  rsp_t sb[$];

  assign dq_a = tb_low ? 1'b0 : 1'bz;
  pullup pu_a (dq_a);
  pullup pu_b (dq_b);

  n64_cic_phy #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .n64_reset(n64_reset), .n64_cic_clk(n64_cic_clk),
    .n64_si_clk(n64_si_clk), .n64_cic_dq(dq_a),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_count(cmd_count), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_abort(rsp_abort),
    .cic_reset(cic_reset), .cic_clk(cic_clk), .cic_dq(cic_dq)
  );

  n64_cic_phy #(.SYNC_STAGES(SYNC), .DIV_WIDTH(2), .TIMEOUT(2)) dut_to (
    .clk(clk), .reset(reset), .n64_reset(n64_reset), .n64_cic_clk(n64_cic_clk),
    .n64_si_clk(n64_si_clk), .n64_cic_dq(dq_b),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
    .cmd_count(cmd_count), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
    .rsp_timeout(rsp_timeout2), .rsp_abort(rsp_abort2),
    .cic_reset(cic_reset2), .cic_clk(cic_clk2), .cic_dq(cic_dq2)
  );

  always #5 clk = ~clk;

  // During receive the bench is the only party allowed to pull DQ low.
  always @(posedge clk) begin
    #3;
    if (rx_mode && !tb_low && dq_a !== 1'b1) rx_viol++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [5:0] cnt, input logic [31:0] d);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready before issue", cmd_ready, 32'd1);
    cmd_write = wr;
    cmd_count = cnt;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_period(input logic wr, input logic bit_v, input int idx);
    @(negedge clk);
    n64_cic_clk = 1'b0;
    if (!wr) tb_low = ~bit_v;
    repeat (8) @(negedge clk);
    if (wr) check($sformatf("tx bit %0d low phase", idx), dq_a, {31'd0, bit_v});
    n64_cic_clk = 1'b1;
    repeat (8) @(negedge clk);
    if (wr) check($sformatf("tx bit %0d released", idx), dq_a, 32'd1);
  endtask

  task automatic collect(input string nm);
    rsp_t e;
    int t;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({nm, " rsp_valid"}, rsp_valid, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty actual=0 required=1", nm);
    end else begin
      e = sb.pop_front();
      check({nm, " rsp_data"}, rsp_data, e.data);
      check({nm, " rsp_timeout"}, rsp_timeout, {31'd0, e.tmo});
      check({nm, " rsp_abort"}, rsp_abort, {31'd0, e.abt});
      repeat (2) @(negedge clk);
      check({nm, " held valid"}, rsp_valid, 32'd1);
      check({nm, " held data"}, rsp_data, e.data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, " valid dropped"}, rsp_valid, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    rsp_t r;
    n = (v.cnt > 6'd32) ? 32 : int'(v.cnt);
    issue(v.wr, v.cnt, v.data);
    r.data = v.exp;
    r.tmo  = 1'b0;
    r.abt  = 1'b0;
    sb.push_back(r);
    rx_mode = !v.wr;
    rx_viol = 0;
    if (n == 0) check($sformatf("vec%0d zero count latency", idx), rsp_valid, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check($sformatf("vec%0d no early rsp", idx), rsp_valid, 32'd0);
      do_period(v.wr, v.data[n-1-i], i);
    end
    tb_low = 1'b0;
    if (!v.wr) check($sformatf("vec%0d rx never drives", idx), rx_viol, 32'd0);
    rx_mode = 1'b0;
    collect($sformatf("vec%0d", idx));
  endtask

  initial begin
    int t;
    rsp_t r;
    vecs[0] = '{1'b1, 6'd4,  32'h0000000A, 32'h00000000};
    vecs[1] = '{1'b0, 6'd8,  32'h0000005A, 32'h0000005A};
    vecs[2] = '{1'b0, 6'd32, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 6'd40, 32'h00000001, 32'h00000000};
    vecs[4] = '{1'b0, 6'd1,  32'h00000001, 32'h00000001};
    vecs[5] = '{1'b1, 6'd0,  32'hFFFFFFFF, 32'h00000000};
    vecs[6] = '{1'b0, 6'd0,  32'hFFFFFFFF, 32'h00000000};
    vecs[7] = '{1'b1, 6'd3,  32'hFFFFFFF5, 32'h00000000};
    vecs[8] = '{1'b0, 6'd5,  32'h00000013, 32'h00000013};

    repeat (3) @(negedge clk);
    check("reset cmd_ready", cmd_ready, 32'd0);
    check("reset rsp_valid", rsp_valid, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset flags", {rsp_timeout, rsp_abort}, 32'd0);
    check("reset dq released", dq_a, 32'd1);
    check("reset sync cleared", cic_reset, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready after reset", cmd_ready, 32'd1);
    repeat (5) @(negedge clk);
    check("sync pin levels", {cic_reset, cic_clk, cic_dq}, 32'd7);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Console drops reset three bits into a 16-bit transmit of zeros.
    issue(1'b1, 6'd16, 32'h0);
    r.data = 32'h0;
    r.tmo  = 1'b0;
    r.abt  = 1'b1;
    sb.push_back(r);
    for (int i = 0; i < 3; i++) do_period(1'b1, 1'b0, i);
    n64_cic_clk = 1'b0;
    repeat (6) @(negedge clk);
    check("abort pre dq low", dq_a, 32'd0);
    n64_reset = 1'b0;
    t = 0;
    while (dq_a !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("abort release latency", (t <= SYNC + 2) ? 32'd1 : 32'd0, 32'd1);
    n64_cic_clk = 1'b1;
    collect("abort");
    n64_reset = 1'b1;
    repeat (6) @(negedge clk);

    // Timeout: 4 si_clk rises per tick, two ticks allowed.
    cmd_write  = 1'b0;
    cmd_count  = 6'd8;
    cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("timeout not before 8th edge", rsp_valid2, 32'd0);
      n64_si_clk = 1'b1;
      repeat (4) @(negedge clk);
      n64_si_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("timeout rsp_valid", rsp_valid2, 32'd1);
    check("timeout flag", rsp_timeout2, 32'd1);
    check("timeout abort flag", rsp_abort2, 32'd0);
    check("timeout rsp_data", rsp_data2, 32'd0);
    rsp_ready2 = 1'b1;
    @(negedge clk);
    rsp_ready2 = 1'b0;

    // Reset pulse while DQ is driven low in WAIT_RISE.
    issue(1'b1, 6'd8, 32'h0);
    n64_cic_clk = 1'b0;
    repeat (6) @(negedge clk);
    check("mid-cmd dq low", dq_a, 32'd0);
    #1 reset = 1'b1;
    #1 check("reset releases dq at once", dq_a, 32'd1);
    check("reset no rsp_valid", rsp_valid, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n64_cic_clk = 1'b1;
    @(negedge clk);
    check("cmd_ready one cycle after reset", cmd_ready, 32'd1);
    repeat (6) @(negedge clk);
    check("discarded command no rsp", rsp_valid, 32'd0);
    run_vec(vecs[1], 9);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
